descriptor_fetch_engine: RTL and testbench

- Walks a chain of 4-word DMA descriptors held in the 512x32 on-chip descriptor memory.
- Reads each descriptor through an Avalon-MM master (fixed read latency 1) and presents it to the downstream DMA dispatcher on a valid/ready interface.
- After the dispatcher accepts a descriptor, writes its control word back with ownership cleared.
- Started by the CPU through a simple command interface; sits between the descriptor memory and the dispatcher.

---
 rtl/descriptor_fetch_engine_if.sv | 42 ++++
 rtl/descriptor_fetch_engine.sv | 198 +++++++++++++++++++
 tb/tb_descriptor_fetch_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/descriptor_fetch_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : descriptor_fetch_engine_if
// Description : Bus bundle between the descriptor fetch engine, the
//               descriptor memory (Avalon-MM, read latency 1) and the
//               downstream DMA dispatcher (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface descriptor_fetch_engine_if #(
    parameter int ADDR_W = 9
);
    // Avalon-MM master side towards the descriptor memory
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_readdata;

    // Descriptor hand-off towards the dispatcher
    logic              d_valid;
    logic              d_ready;
    logic [31:0]       d_rd_addr;
    logic [31:0]       d_wr_addr;
    logic [31:0]       d_length;
    logic [31:0]       d_control;

    modport master (
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_readdata,
        output d_valid, d_rd_addr, d_wr_addr, d_length, d_control,
        input  d_ready
    );

    modport slave (
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_readdata,
        input  d_valid, d_rd_addr, d_wr_addr, d_length, d_control,
        output d_ready
    );
endinterface
`default_nettype wire

// File: rtl/descriptor_fetch_engine.sv
`default_nettype none
// ============================================================================
// Module      : descriptor_fetch_engine
// Description : Walks a chain of 4-word DMA descriptors in on-chip memory,
//               hands each one to the dispatcher and writes its control
//               word back with ownership cleared and DONE set.
// Revision    : 1.0 - initial release
// ============================================================================
module descriptor_fetch_engine #(
    parameter int ADDR_W   = 9,
    parameter int MAX_DESC = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              error,
    descriptor_fetch_engine_if.master bus
);

    localparam int              c_CNT_W      = $clog2(MAX_DESC + 1);
    localparam logic [ADDR_W-1:0] c_ALIGN_MSK = ~ADDR_W'(3);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_CHECK     = 3'd2,
        S_ISSUE     = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_ptr;
    logic [2:0]           r_idx;        // FETCH beat: 0..3 issue reads, 1..4 capture
    logic [31:0]          r_word [4];
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_error;

    logic                 w_own;
    logic                 w_last;
    logic                 w_len_zero;
    logic                 w_cnt_max;
    logic [1:0]           w_cap_sel;
    logic [ADDR_W-1:0]    w_next_ptr;
    logic [ADDR_W-1:0]    w_wb_addr;
    logic [31:0]          w_wb_data;
    logic                 w_finish_after_wb;

    logic                 w_m_read;
    logic                 w_m_write;
    logic [ADDR_W-1:0]    w_m_address;
    logic [31:0]          w_m_writedata;
    logic                 w_d_valid;

    assign w_own             = r_word[3][31];
    assign w_last            = r_word[3][30];
    assign w_len_zero        = (r_word[2] == 32'd0);
    assign w_cnt_max         = (r_count == c_CNT_W'(MAX_DESC));
    // Beat k captures the data of the read issued at beat k-1 (beat 4 -> word 3)
    assign w_cap_sel         = r_idx[1:0] - 2'd1;
    assign w_next_ptr        = r_word[3][16 +: ADDR_W] & c_ALIGN_MSK;
    assign w_wb_addr         = {r_ptr[ADDR_W-1:2], 2'b11};
    assign w_wb_data         = {1'b0, r_word[3][30], 1'b1, r_word[3][28:0]};
    assign w_finish_after_wb = w_last | stop;

    assign bus.m_read        = w_m_read;
    assign bus.m_write       = w_m_write;
    assign bus.m_address     = w_m_address;
    assign bus.m_writedata   = w_m_writedata;
    assign bus.m_byteenable  = 4'hF;
    assign bus.d_valid       = w_d_valid;
    assign bus.d_rd_addr     = r_word[0];
    assign bus.d_wr_addr     = r_word[1];
    assign bus.d_length      = r_word[2];
    assign bus.d_control     = r_word[3];
    assign error             = r_error;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and bus strobes; address is parked at 0 when idle
    always_comb begin
        w_state_nxt   = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        w_m_read      = 1'b0;
        w_m_write     = 1'b0;
        w_m_address   = '0;
        w_m_writedata = 32'd0;
        w_d_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (r_idx != 3'd4) begin
                    w_m_read    = 1'b1;
                    w_m_address = {r_ptr[ADDR_W-1:2], r_idx[1:0]};
                end else begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (!w_own || w_len_zero || w_cnt_max) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                w_d_valid = 1'b1;
                if (bus.d_ready) begin
                    w_state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                busy          = 1'b1;
                w_m_write     = 1'b1;
                w_m_address   = w_wb_addr;
                w_m_writedata = w_wb_data;
                w_state_nxt   = w_finish_after_wb ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pointer, descriptor word capture, hand-off count and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_idx   <= 3'd0;
            r_count <= '0;
            r_error <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_word[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr   <= start_addr & c_ALIGN_MSK;
                        r_idx   <= 3'd0;
                        r_count <= '0;
                        r_error <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (r_idx != 3'd0) begin
                        r_word[w_cap_sel] <= bus.m_readdata;
                    end
                    r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
                end
                S_CHECK: begin
                    // A non-owned descriptor ends the chain cleanly, not as an error
                    if (w_own && (w_len_zero || w_cnt_max)) begin
                        r_error <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.d_ready) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                S_WRITEBACK: begin
                    if (!w_finish_after_wb) begin
                        r_ptr <= w_next_ptr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_descriptor_fetch_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_descriptor_fetch_engine
// Description : Self-checking bench for descriptor_fetch_engine with a
//               memory model, dispatcher model and chain-walk reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_descriptor_fetch_engine;

    localparam int ADDR_W   = 9;
    localparam int MAX_DESC = 128;
    localparam logic [31:0] OWN_B  = 32'h8000_0000;
    localparam logic [31:0] LAST_B = 32'h4000_0000;
    localparam logic [31:0] DONE_B = 32'h2000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              stop = 1'b0;
    logic              busy, done, error;

    descriptor_fetch_engine_if #(.ADDR_W(ADDR_W)) bus ();

    descriptor_fetch_engine #(.ADDR_W(ADDR_W), .MAX_DESC(MAX_DESC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0]  mem [512];
    logic [31:0]  rdata = 32'd0;
    bit           restore_own = 1'b0;
    int           ready_delay = 0;
    bit           early_ready = 1'b0;

    logic [8:0]   rd_q[$];
    logic [127:0] hand_q[$];
    logic [40:0]  wr_q[$];
    int           done_cnt = 0;
    int           stall_viol = 0;
    int           both_viol = 0;
    int           addr_viol = 0;

    logic [8:0]   exp_rd[$];
    logic [127:0] exp_hand[$];
    logic [40:0]  exp_wr[$];
    logic         exp_err;

    assign bus.m_readdata = rdata;

    // Descriptor memory: read data valid one cycle after the strobe
    always @(posedge clk) begin
        if (bus.m_read) rdata <= mem[bus.m_address];
        if (bus.m_write) mem[bus.m_address] = restore_own ? (bus.m_writedata | OWN_B) : bus.m_writedata;
    end

    // Dispatcher model and bus monitor, evaluated mid-cycle
    int           vcnt = 0;
    bit           prev_stall = 1'b0;
    logic [127:0] stall_snap = '0;
    always @(negedge clk) begin
        logic         nr;
        logic [127:0] f;
        f = {bus.d_rd_addr, bus.d_wr_addr, bus.d_length, bus.d_control};
        if (bus.d_valid) begin
            nr = (vcnt >= ready_delay);
            vcnt++;
        end else begin
            nr = early_ready ? ($urandom_range(0, 1) == 1) : 1'b0;
            vcnt = 0;
        end
        bus.d_ready = nr;
        if (bus.d_valid && prev_stall && (f !== stall_snap)) stall_viol++;
        prev_stall = bus.d_valid && !nr;
        stall_snap = f;
        if (bus.d_valid && nr) hand_q.push_back(f);
        if (bus.m_read) rd_q.push_back(bus.m_address);
        if (bus.m_write) wr_q.push_back({bus.m_address, bus.m_writedata});
        if (bus.m_read && bus.m_write) both_viol++;
        if (!bus.m_read && !bus.m_write && bus.m_address != '0) addr_viol++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    endtask

    task automatic put_desc(input logic [8:0] b, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] l, input logic [31:0] c);
        mem[b] = s; mem[b + 1] = d; mem[b + 2] = l; mem[b + 3] = c;
    endtask

    function automatic logic [31:0] mk_ctrl(input bit own, input bit last, input logic [8:0] nxt);
        logic [31:0] r;
        r = $urandom;
        r[31] = own; r[30] = last; r[29] = 1'b0; r[24:16] = nxt;
        return r;
    endfunction

    // Reference: walk the chain over a private copy of memory
    task automatic model(input logic [8:0] sa, input int stop_at);
        logic [31:0] mm [512];
        logic [31:0] w0, w1, w2, w3, wb;
        logic [8:0]  p;
        int          n;
        mm = mem;
        exp_rd.delete(); exp_hand.delete(); exp_wr.delete();
        exp_err = 1'b0; n = 0;
        p = sa & 9'h1FC;
        forever begin
            for (int k = 0; k < 4; k++) exp_rd.push_back(p + 9'(k));
            w0 = mm[p]; w1 = mm[p + 1]; w2 = mm[p + 2]; w3 = mm[p + 3];
            if (!w3[31]) break;
            if (w2 == 32'd0 || n == MAX_DESC) begin exp_err = 1'b1; break; end
            exp_hand.push_back({w0, w1, w2, w3});
            n++;
            wb = (w3 & ~OWN_B) | DONE_B;
            exp_wr.push_back({p + 9'd3, wb});
            mm[p + 3] = restore_own ? (wb | OWN_B) : wb;
            if (w3[30] || (stop_at != 0 && n == stop_at)) break;
            p = w3[24:16] & 9'h1FC;
        end
    endtask

    task automatic clear_logs();
        rd_q.delete(); hand_q.delete(); wr_q.delete();
        done_cnt = 0; stall_viol = 0; both_viol = 0; addr_viol = 0;
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_nrd"}, 128'(rd_q.size()), 128'(exp_rd.size()));
        foreach (exp_rd[i]) if (i < rd_q.size()) chk({tag, "_rd"}, 128'(rd_q[i]), 128'(exp_rd[i]));
        chk({tag, "_nhand"}, 128'(hand_q.size()), 128'(exp_hand.size()));
        foreach (exp_hand[i]) if (i < hand_q.size()) chk({tag, "_hand"}, hand_q[i], exp_hand[i]);
        chk({tag, "_nwr"}, 128'(wr_q.size()), 128'(exp_wr.size()));
        foreach (exp_wr[i]) if (i < wr_q.size()) chk({tag, "_wr"}, 128'(wr_q[i]), 128'(exp_wr[i]));
        chk({tag, "_stall"}, 128'(stall_viol), 128'(0));
        chk({tag, "_rdwr"}, 128'(both_viol), 128'(0));
        chk({tag, "_addr0"}, 128'(addr_viol), 128'(0));
    endtask

    task automatic run_chain(input logic [8:0] sa, input int stop_at, input bit poke, input string tag);
        int cyc;
        model(sa, stop_at);
        clear_logs();
        start_addr = sa; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        chk({tag, "_errclr"}, 128'(error), 128'(0));
        if (poke) begin
            start_addr = 9'h1F0; start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 6000) begin
            if (stop_at != 0 && bus.d_valid && hand_q.size() == stop_at - 1) stop = 1'b1;
            @(negedge clk); #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, 128'(done_cnt != 0), 128'(1));
        chk({tag, "_busy_end"}, 128'(busy), 128'(0));
        stop = 1'b0;
        @(negedge clk); #1;
        chk({tag, "_done_pulse"}, 128'(done), 128'(0));
        chk({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
        chk({tag, "_error"}, 128'(error), 128'(exp_err));
        compare_logs(tag);
    endtask

    initial begin
        logic [8:0] a [4];
        int n, slot;
        clear_mem();
        bus.d_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        chk("rst_ctl", 128'({busy, done, error, bus.m_read, bus.m_write, bus.d_valid}), 128'(0));
        chk("rst_addr", 128'(bus.m_address), 128'(0));
        chk("rst_be", 128'(bus.m_byteenable), 128'(4'hF));
        chk("rst_d", {bus.d_rd_addr, bus.d_wr_addr, bus.d_length, bus.d_control}, 128'(0));
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Single descriptor
        put_desc(9'h010, 32'h1000, 32'h2000, 32'h40, 32'hC000_0000);
        run_chain(9'h010, 0, 1'b0, "single");
        if (wr_q.size() > 0) chk("single_wb_const", 128'(wr_q[0]), 128'({9'h013, 32'h6000_0000}));

        // Zero length, owned: error
        clear_mem();
        put_desc(9'h030, $urandom, $urandom, 32'd0, mk_ctrl(1'b1, 1'b1, 9'h0));
        run_chain(9'h030, 0, 1'b0, "len0");

        // Three-descriptor chain with stalled dispatcher; a start while busy is ignored
        clear_mem();
        ready_delay = 3;
        put_desc(9'h000, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b0, 9'h020));
        put_desc(9'h020, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b0, 9'h040));
        put_desc(9'h040, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b1, 9'h000));
        mem[9'h1F3] = 32'hC000_0000; mem[9'h1F2] = 32'h10;
        run_chain(9'h000, 0, 1'b1, "chain3");

        // Not owned at start
        clear_mem();
        ready_delay = 0;
        put_desc(9'h050, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b0, 1'b0, 9'h060));
        run_chain(9'h050, 0, 1'b0, "own0");

        // Stop raised while the first of three is offered
        clear_mem();
        ready_delay = 2;
        put_desc(9'h100, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b0, 9'h104));
        put_desc(9'h104, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b0, 9'h108));
        put_desc(9'h108, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b1, 9'h000));
        run_chain(9'h100, 1, 1'b0, "stop");

        // Self-loop hits the chain-length limit
        clear_mem();
        ready_delay = 0; early_ready = 1'b1; restore_own = 1'b1;
        put_desc(9'h0C0, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b0, 9'h0C2));
        run_chain(9'h0C1, 0, 1'b0, "selfloop");
        chk("selfloop_count", 128'(hand_q.size()), 128'(MAX_DESC));
        restore_own = 1'b0; early_ready = 1'b0;

        // Reset during the third fetch read
        clear_mem();
        put_desc(9'h080, $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, 1'b1, 9'h000));
        clear_logs();
        start_addr = 9'h080; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(bus.m_read && bus.m_address == 9'h082) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("midrst_reached", 128'(n < 20), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", 128'({busy, done, error, bus.m_read, bus.m_write, bus.d_valid}), 128'(0));
        chk("midrst_addr", 128'(bus.m_address), 128'(0));
        chk("midrst_d", {bus.d_rd_addr, bus.d_wr_addr, bus.d_length, bus.d_control}, 128'(0));
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_nowr", 128'(wr_q.size()), 128'(0));
        rst_n = 1'b1;
        @(negedge clk); #1;
        run_chain(9'h080, 0, 1'b0, "after_rst");

        // Randomized chains with misaligned pointers
        for (int it = 0; it < 6; it++) begin
            clear_mem();
            ready_delay = $urandom_range(0, 4);
            early_ready = ($urandom_range(0, 1) == 1);
            n = $urandom_range(1, 4);
            slot = $urandom_range(0, 127);
            for (int i = 0; i < n; i++) a[i] = 9'(((slot + i * 37) % 128) * 4);
            for (int i = 0; i < n; i++) begin
                logic [8:0] nx;
                nx = (i + 1 < n) ? (a[i + 1] | 9'($urandom_range(0, 3))) : 9'($urandom);
                put_desc(a[i], $urandom, $urandom, $urandom | 1, mk_ctrl(1'b1, (i + 1 == n), nx));
            end
            run_chain(a[0] | 9'($urandom_range(0, 3)), 0, 1'b0, "rand");
        end
        early_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
